// File: rtl/spike_wta_classifier.sv
// spike_wta_classifier
//   Counts spikes per neuron over a window of en-qualified cycles, drives
//   lateral inhibition back to the neuron array, and at window end scans the
//   counters for the winner, offering it on a valid/ready handshake.
//   Optional feature macro: WTA_LATERAL_INH_EN (inhibition logic). When the
//   macro is not defined, inh is tied low and the hold timer is absent.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start
//   ST_RUN  | window open, spikes counted on en cycles, inhibition active
//   ST_SCAN | one counter compared per clk, en ignored
//   ST_DONE | result_valid high, waiting for result_ready
module spike_wta_classifier #(
  parameter int N_NEURONS = 4,
  parameter int CNT_W     = 8,
  parameter int T_WINDOW  = 250,
  parameter int INH_HOLD  = 5,
  localparam int IDX_W    = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 start,
  input  logic [N_NEURONS-1:0] spikes,
  output logic [N_NEURONS-1:0] inh,
  output logic                 busy,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [IDX_W-1:0]     winner_idx,
  output logic [CNT_W-1:0]     winner_cnt
);

  localparam int WIN_W = $clog2(T_WINDOW + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SCAN, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   cnt_q [N_NEURONS];
  logic [CNT_W-1:0]   cnt_d [N_NEURONS];
  logic [IDX_W-1:0]   scan_q, scan_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [CNT_W-1:0]   best_cnt_q, best_cnt_d;
  logic [IDX_W-1:0]   winner_idx_q, winner_idx_d;
  logic [CNT_W-1:0]   winner_cnt_q, winner_cnt_d;
  logic               valid_q, valid_d;
  logic               win_last;

  // Window timer is a down-counter; the terminal count marks the final window cycle.
  assign win_last = (state_q == ST_RUN) && en && (win_q == '0);

  // Next-state, window timer, spike counters and argmax scan.
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    scan_d       = scan_q;
    best_idx_d   = best_idx_q;
    best_cnt_d   = best_cnt_q;
    winner_idx_d = winner_idx_q;
    winner_cnt_d = winner_cnt_q;
    valid_d      = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          win_d   = WIN_W'(T_WINDOW - 1);
          for (int i = 0; i < N_NEURONS; i++) cnt_d[i] = '0;
        end
      end
      ST_RUN: begin
        if (en) begin
          for (int i = 0; i < N_NEURONS; i++) begin
            if (spikes[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
          if (win_q == '0) begin
            state_d    = ST_SCAN;
            scan_d     = '0;
            best_idx_d = '0;
            best_cnt_d = '0;
          end else begin
            win_d = win_q - WIN_W'(1);
          end
        end
      end
      ST_SCAN: begin
        // Strict greater-than keeps the lowest index on ties.
        if (cnt_q[scan_q] > best_cnt_q) begin
          best_idx_d = scan_q;
          best_cnt_d = cnt_q[scan_q];
        end
        if (scan_q == IDX_W'(N_NEURONS - 1)) begin
          state_d      = ST_DONE;
          winner_idx_d = best_idx_d;
          winner_cnt_d = best_cnt_d;
          valid_d      = 1'b1;
        end else begin
          scan_d = scan_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (result_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      win_q        <= '0;
      cnt_q        <= '{default: '0};
      scan_q       <= '0;
      best_idx_q   <= '0;
      best_cnt_q   <= '0;
      winner_idx_q <= '0;
      winner_cnt_q <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      scan_q       <= scan_d;
      best_idx_q   <= best_idx_d;
      best_cnt_q   <= best_cnt_d;
      winner_idx_q <= winner_idx_d;
      winner_cnt_q <= winner_cnt_d;
      valid_q      <= valid_d;
    end
  end

`ifdef WTA_LATERAL_INH_EN
  localparam int HOLD_W = $clog2(INH_HOLD + 1);

  logic [N_NEURONS-1:0] inh_q, inh_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [IDX_W-1:0]     trig_idx;
  logic [N_NEURONS-1:0] trig_onehot;

  // Lowest-index spiking neuron is the one left uninhibited.
  always_comb begin
    trig_idx    = '0;
    trig_onehot = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (spikes[i]) trig_idx = IDX_W'(i);
    end
    trig_onehot[trig_idx] = 1'b1;
  end

  // Inhibition pattern and hold timer; en low freezes both.
  always_comb begin
    inh_d  = inh_q;
    hold_d = hold_q;
    if ((state_q != ST_RUN) || win_last) begin
      inh_d  = '0;
      hold_d = '0;
    end else if (en && (|spikes)) begin
      inh_d  = ~trig_onehot;
      hold_d = HOLD_W'(INH_HOLD);
    end else if (en && (hold_q != '0)) begin
      hold_d = hold_q - HOLD_W'(1);
      if (hold_q == HOLD_W'(1)) inh_d = '0;
    end
  end

  // Inhibition registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inh_q  <= '0;
      hold_q <= '0;
    end else begin
      inh_q  <= inh_d;
      hold_q <= hold_d;
    end
  end

  assign inh = inh_q;
`else
  assign inh = '0;
`endif

  assign busy         = (state_q == ST_RUN) || (state_q == ST_SCAN);
  assign result_valid = valid_q;
  assign winner_idx   = winner_idx_q;
  assign winner_cnt   = winner_cnt_q;

endmodule
